// File: rtl/game_status.sv
// Game-state and scoring tracker feeding the endgame renderer: pellets, ghost-combo
// scoring with a four-digit saturating score, lives with a death freeze, win/lose.
module game_status #(
    parameter int PELLET_TOTAL = 244,
    parameter int START_LIVES  = 3,
    parameter int PELLET_PTS   = 10,
    parameter int POWER_PTS    = 50,
    parameter int GHOST_BASE   = 200,
    parameter int SCORE_MAX    = 9999,
    parameter int DEATH_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        pacman_caught,
    output logic [31:0] score,
    output logic [2:0]  lives,
    output logic [8:0]  pellets_left,
    output logic        win,
    output logic        lose,
    output logic        playing,
    output logic        respawn
);

    localparam int FRZ_W = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    state_t             state_r, state_next_s;
    logic [1:0]         rst_sync_r;
    logic               srst_s;
    logic [31:0]        score_r, score_next_s;
    logic [2:0]         lives_r, lives_next_s;
    logic [8:0]         pellets_r, pellets_next_s;
    logic [1:0]         combo_r, combo_next_s;
    logic [FRZ_W-1:0]   freeze_r, freeze_next_s;
    logic               respawn_next_s;
    logic               win_next_s, lose_next_s, playing_next_s;
    logic               win_r, lose_r, playing_r, respawn_r;
    logic [1:0]         eaten_cnt_s;
    logic [1:0]         combo_base_s;
    logic [31:0]        incr_s;
    logic [8:0]         pellets_dec_s;

    function automatic logic [31:0] sat_score(input logic [31:0] base, input logic [31:0] incr);
        logic [31:0] sum;
        sum = base + incr;
        if (sum > 32'(SCORE_MAX)) begin
            sat_score = 32'(SCORE_MAX);
        end else begin
            sat_score = sum;
        end
    endfunction

    function automatic logic [1:0] combo_inc(input logic [1:0] c);
        if (c == 2'd3) begin
            combo_inc = 2'd3;
        end else begin
            combo_inc = c + 2'd1;
        end
    endfunction

    // Reset release is synchronised; until it propagates the block behaves as if in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign srst_s       = ~rst_sync_r[1];
    assign eaten_cnt_s  = {1'b0, pellet_eaten} + {1'b0, power_eaten};
    // A power pellet restarts the combo before this cycle's ghost is scored
    assign combo_base_s = power_eaten ? 2'd0 : combo_r;
    assign incr_s       = (pellet_eaten ? 32'(PELLET_PTS) : 32'd0)
                        + (power_eaten  ? 32'(POWER_PTS)  : 32'd0)
                        + (ghost_eaten  ? (32'(GHOST_BASE) << combo_base_s) : 32'd0);
    assign pellets_dec_s = (pellets_r > {7'd0, eaten_cnt_s}) ? (pellets_r - {7'd0, eaten_cnt_s}) : 9'd0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_next_s   = state_r;
        score_next_s   = score_r;
        lives_next_s   = lives_r;
        pellets_next_s = pellets_r;
        combo_next_s   = combo_r;
        freeze_next_s  = freeze_r;
        respawn_next_s = 1'b0;
        if (srst_s) begin
            state_next_s   = ST_IDLE;
            score_next_s   = 32'd0;
            lives_next_s   = 3'(START_LIVES);
            pellets_next_s = 9'(PELLET_TOTAL);
            combo_next_s   = 2'd0;
            freeze_next_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state_next_s   = ST_PLAY;
                        score_next_s   = 32'd0;
                        lives_next_s   = 3'(START_LIVES);
                        pellets_next_s = 9'(PELLET_TOTAL);
                        combo_next_s   = 2'd0;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_PLAY: begin
                    score_next_s   = sat_score(score_r, incr_s);
                    pellets_next_s = pellets_dec_s;
                    combo_next_s   = ghost_eaten ? combo_inc(combo_base_s) : combo_base_s;
                    // Clearing the maze outranks a catch; an eaten ghost cannot catch
                    if (pellets_dec_s == 9'd0) begin
                        state_next_s = ST_WIN;
                    end else if (pacman_caught && !ghost_eaten) begin
                        lives_next_s = lives_r - 3'd1;
                        if (lives_r == 3'd1) begin
                            state_next_s = ST_LOSE;
                        end else begin
                            state_next_s  = ST_DYING;
                            freeze_next_s = '0;
                        end
                    end else begin
                        state_next_s = ST_PLAY;
                    end
                end
                ST_DYING: begin
                    if (frame_tick) begin
                        freeze_next_s = freeze_r + FRZ_W'(1);
                        if ((freeze_r + FRZ_W'(1)) == FRZ_W'(DEATH_FRAMES)) begin
                            state_next_s   = ST_PLAY;
                            respawn_next_s = 1'b1;
                            combo_next_s   = 2'd0;
                        end else begin
                            state_next_s = ST_DYING;
                        end
                    end else begin
                        state_next_s = ST_DYING;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decoded from the upcoming state so they register alongside the counters
    always_comb begin
        win_next_s     = 1'b0;
        lose_next_s    = 1'b0;
        playing_next_s = 1'b0;
        case (state_next_s)
            ST_WIN:  win_next_s     = 1'b1;
            ST_LOSE: lose_next_s    = 1'b1;
            ST_PLAY: playing_next_s = 1'b1;
            default: begin
                win_next_s     = 1'b0;
                lose_next_s    = 1'b0;
                playing_next_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_r   <= 32'd0;
            lives_r   <= 3'(START_LIVES);
            pellets_r <= 9'(PELLET_TOTAL);
            combo_r   <= 2'd0;
            freeze_r  <= '0;
            win_r     <= 1'b0;
            lose_r    <= 1'b0;
            playing_r <= 1'b0;
            respawn_r <= 1'b0;
        end else begin
            score_r   <= score_next_s;
            lives_r   <= lives_next_s;
            pellets_r <= pellets_next_s;
            combo_r   <= combo_next_s;
            freeze_r  <= freeze_next_s;
            win_r     <= win_next_s;
            lose_r    <= lose_next_s;
            playing_r <= playing_next_s;
            respawn_r <= respawn_next_s;
        end
    end

    assign score        = score_r;
    assign lives        = lives_r;
    assign pellets_left = pellets_r;
    assign win          = win_r;
    assign lose         = lose_r;
    assign playing      = playing_r;
    assign respawn      = respawn_r;

endmodule

// File: tb/tb_game_status.sv
// Bench for game_status: directed vector table, hand-written death/win/saturation/reset
// sequences, and random play compared against an arithmetic reference model.
module tb_game_status;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0, start = 1'b0, pellet_eaten = 1'b0;
    logic        power_eaten = 1'b0, ghost_eaten = 1'b0, pacman_caught = 1'b0;
    logic [31:0] score;
    logic [2:0]  lives;
    logic [8:0]  pellets_left;
    logic        win, lose, playing, respawn;

    game_status dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten), .ghost_eaten(ghost_eaten),
        .pacman_caught(pacman_caught), .score(score), .lives(lives),
        .pellets_left(pellets_left), .win(win), .lose(lose), .playing(playing),
        .respawn(respawn)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 play, 2 dying, 3 win, 4 lose
    int m_mode, m_score, m_lives, m_pel, m_combo, m_frz, m_resp, m_edges;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        m_mode = 0; m_score = 0; m_lives = 3; m_pel = 244; m_combo = 0; m_frz = 0; m_resp = 0;
    endtask

    task automatic model_edge();
        int inc;
        bit active;
        m_resp = 0;
        if (!reset) begin
            model_clear();
            m_edges = 0;
        end else begin
            active = (m_edges >= 2);
            if (m_edges < 2) m_edges++;
            if (!active) begin
                model_clear();
            end else if (m_mode == 0 || m_mode == 3 || m_mode == 4) begin
                if (start) begin
                    m_mode = 1; m_score = 0; m_lives = 3; m_pel = 244; m_combo = 0;
                end
            end else if (m_mode == 1) begin
                inc = (pellet_eaten ? 10 : 0) + (power_eaten ? 50 : 0);
                if (power_eaten) m_combo = 0;
                if (ghost_eaten) begin
                    inc += 200 * (2 ** m_combo);
                    m_combo = (m_combo < 3) ? m_combo + 1 : 3;
                end
                m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
                m_pel = m_pel - int'(pellet_eaten) - int'(power_eaten);
                if (m_pel < 0) m_pel = 0;
                if (m_pel == 0) m_mode = 3;
                else if (pacman_caught && !ghost_eaten) begin
                    m_lives--;
                    if (m_lives == 0) m_mode = 4;
                    else begin m_mode = 2; m_frz = 0; end
                end
            end else if (m_mode == 2) begin
                if (frame_tick) begin
                    m_frz++;
                    if (m_frz == 120) begin m_resp = 1; m_combo = 0; m_mode = 1; end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("score", int'(score), m_score);
        chk("lives", int'(lives), m_lives);
        chk("pellets_left", int'(pellets_left), m_pel);
        chk("win", int'(win), int'(m_mode == 3));
        chk("lose", int'(lose), int'(m_mode == 4));
        chk("playing", int'(playing), int'(m_mode == 1));
        chk("respawn", int'(respawn), m_resp);
    endtask

    task automatic cycle(input bit s, input bit pe, input bit pw, input bit gh, input bit pc, input bit ft);
        start = s; pellet_eaten = pe; power_eaten = pw; ghost_eaten = gh;
        pacman_caught = pc; frame_tick = ft;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic freeze_ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    typedef struct {
        bit st, pe, pw, gh, pc;
        int e_score, e_pel, e_lives, e_play;
    } vec_t;

    vec_t vecs[13];
    bit resp_seen;

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 0,    0, 244, 3, 1};
        vecs[1]  = '{0, 1, 1, 0, 0,   60, 242, 3, 1};
        vecs[2]  = '{1, 0, 0, 0, 0,   60, 242, 3, 1};
        vecs[3]  = '{0, 0, 1, 0, 0,  110, 241, 3, 1};
        vecs[4]  = '{0, 0, 0, 1, 0,  310, 241, 3, 1};
        vecs[5]  = '{0, 0, 0, 1, 0,  710, 241, 3, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, 1510, 241, 3, 1};
        vecs[7]  = '{0, 0, 0, 1, 0, 3110, 241, 3, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, 4710, 241, 3, 1};
        vecs[9]  = '{0, 0, 1, 1, 0, 4960, 240, 3, 1};
        vecs[10] = '{0, 0, 0, 1, 0, 5360, 240, 3, 1};
        vecs[11] = '{0, 0, 0, 1, 1, 6160, 240, 3, 1};
        vecs[12] = '{0, 1, 0, 1, 0, 7770, 239, 3, 1};

        model_clear();
        m_edges = 0;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_pellets", int'(pellets_left), 244);
        chk("rst_playing", int'(playing), 0);
        chk("rst_win_lose", int'({win, lose}), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].st, vecs[i].pe, vecs[i].pw, vecs[i].gh, vecs[i].pc, 1'b0);
            chk($sformatf("vec%0d_score", i), int'(score), vecs[i].e_score);
            chk($sformatf("vec%0d_pellets", i), int'(pellets_left), vecs[i].e_pel);
            chk($sformatf("vec%0d_lives", i), int'(lives), vecs[i].e_lives);
            chk($sformatf("vec%0d_playing", i), int'(playing), vecs[i].e_play);
        end

        // Death: the tick on the catch cycle must not count
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("death_lives", int'(lives), 2);
        chk("death_playing", int'(playing), 0);
        for (int i = 0; i < 119; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            if (i % 10 == 0) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("freeze_119_respawn", int'(respawn), 0);
        chk("freeze_119_playing", int'(playing), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("respawn_pulse", int'(respawn), 1);
        chk("respawn_playing", int'(playing), 1);
        chk("respawn_score", int'(score), 7770);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("respawn_one_cycle", int'(respawn), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("death2_lives", int'(lives), 1);
        freeze_ticks(120);
        chk("death2_respawn", int'(respawn), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lose_lives", int'(lives), 0);
        chk("lose_flag", int'(lose), 1);
        chk("lose_no_win", int'(win), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("lose_score_held", int'(score), 7770);
        chk("lose_held", int'(lose), 1);

        // Restart from LOSE, then clear the maze with a simultaneous catch
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_score", int'(score), 0);
        chk("restart_lives", int'(lives), 3);
        chk("restart_pellets", int'(pellets_left), 244);
        chk("restart_lose", int'(lose), 0);
        for (int i = 0; i < 243; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("one_left", int'(pellets_left), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("win_flag", int'(win), 1);
        chk("win_lives", int'(lives), 3);
        chk("win_pellets", int'(pellets_left), 0);
        chk("win_score", int'(score), 2440);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("win_held_score", int'(score), 2440);

        // Saturation at 9999
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int g = 0; g < 4; g++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("combo_rounds", int'(score), 9150);
        for (int i = 0; i < 81; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_sat", int'(score), 9960);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_power", int'(score), 9999);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_hold", int'(score), 9999);
        chk("sat_pellets", int'(pellets_left), 158);

        // Reset in the middle of the death freeze
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        freeze_ticks(50);
        reset = 1'b0;
        #1;
        model_clear();
        m_edges = 0;
        compare_all();
        chk("midrst_playing", int'(playing), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_respawn", int'(respawn), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sync_edge1", int'(playing), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sync_edge2", int'(playing), 0);
        resp_seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            resp_seen |= respawn;
        end
        chk("no_respawn_after_reset", int'(resp_seen), 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_start", int'(playing), 1);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
